// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with stalls, optional /2 scaling,
// optional trivial -j rotation and a flush that drains the feedback memory.
module sdf_r2_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int SCALE = 1,
   parameter int NEG_J = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_in,
   input  logic [WIDTH-1:0] in_re,
   input  logic [WIDTH-1:0] in_im,
   input  logic             flush_in,
   output logic             enable_out,
   output logic [WIDTH-1:0] out_re,
   output logic [WIDTH-1:0] out_im,
   output logic             busy
);

   localparam int PB = $clog2(DEPTH);
   localparam int CW = PB + 1 + ((NEG_J != 0) ? 1 : 0);
   localparam logic [PB:0] P0_LAST = (PB+1)'(DEPTH - 1);
   localparam logic [PB:0] P1_LAST = (PB+1)'(2 * DEPTH - 1);
   localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   logic [CW-1:0]    cnt;
   logic             pending;
   logic [WIDTH-1:0] mem_re [DEPTH];
   logic [WIDTH-1:0] mem_im [DEPTH];

   logic             adv;
   logic             phase;
   logic             rot;
   logic             flush_done;
   logic [WIDTH-1:0] x_re, x_im, xr_re, xr_im;
   logic [WIDTH-1:0] d_re, d_im, a_re, a_im, b_re, b_im;
   logic [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;

   function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
      return (v == S_MIN) ? S_MAX : (~v + WIDTH'(1));
   endfunction

   assign adv   = enable_in | (flush_in & ~enable_in & pending);
   assign phase = cnt[PB];
   assign d_re  = mem_re[DEPTH-1];
   assign d_im  = mem_im[DEPTH-1];
   assign busy  = pending;
   // Flush completes on the last phase-0 sample when no real data arrives.
   assign flush_done = ~phase & (cnt[PB:0] == P0_LAST) & ~enable_in;

   generate
      if (NEG_J != 0) begin : g_rot
         assign rot = (cnt[CW-1:CW-2] == 2'b11);
      end else begin : g_norot
         assign rot = 1'b0;
      end
   endgenerate

   always_comb begin
      x_re  = enable_in ? in_re : '0;
      x_im  = enable_in ? in_im : '0;
      xr_re = x_re;
      xr_im = x_im;
      if (rot) begin
         xr_re = x_im;
         xr_im = sat_neg(x_re);
      end
      sum_re = {d_re[WIDTH-1], d_re} + {xr_re[WIDTH-1], xr_re};
      sum_im = {d_im[WIDTH-1], d_im} + {xr_im[WIDTH-1], xr_im};
      dif_re = {d_re[WIDTH-1], d_re} - {xr_re[WIDTH-1], xr_re};
      dif_im = {d_im[WIDTH-1], d_im} - {xr_im[WIDTH-1], xr_im};
      a_re   = (SCALE != 0) ? sum_re[WIDTH:1] : sum_re[WIDTH-1:0];
      a_im   = (SCALE != 0) ? sum_im[WIDTH:1] : sum_im[WIDTH-1:0];
      b_re   = (SCALE != 0) ? dif_re[WIDTH:1] : dif_re[WIDTH-1:0];
      b_im   = (SCALE != 0) ? dif_im[WIDTH:1] : dif_im[WIDTH-1:0];
   end

   // Delay line is deliberately unreset; pending masks its stale contents.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            mem_re[i] <= mem_re[i-1];
            mem_im[i] <= mem_im[i-1];
         end
         mem_re[0] <= phase ? b_re : xr_re;
         mem_im[0] <= phase ? b_im : xr_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         pending    <= 1'b0;
         enable_out <= 1'b0;
         out_re     <= '0;
         out_im     <= '0;
      end else if (adv) begin
         out_re     <= phase ? a_re : d_re;
         out_im     <= phase ? a_im : d_im;
         enable_out <= phase | pending;
         if (flush_done) begin
            cnt     <= '0;
            pending <= 1'b0;
         end else begin
            cnt <= cnt + CW'(1);
            if (cnt[PB:0] == P1_LAST) pending <= 1'b1;
         end
      end else begin
         enable_out <= 1'b0;
      end
   end

endmodule
